vend_dispense_ctrl: RTL and testbench
=====================================

Name: vend_dispense_ctrl

Overview:
- Sequences the vending machine's physical actuators: the product-dispense motor and the change-return solenoid.
- Accepts one-cycle vend and change requests from the coin-acceptance FSM and holds them in a small queue.
- Executes queued requests one at a time, with a drop-sensor handshake, a timeout and fault reporting.
- Sits between the coin FSM outputs and the actuator drivers.

Parameters:
- PULSE_CYCLES, 4: coin_ret on-time in clocks; must be ≥ 1.
- TIMEOUT_CYCLES, 255: maximum motor_on duration without motor_done before a timeout; must be ≥ 2.
- QDEPTH, 4: request queue depth; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- vend_in  in  1  request: dispense one item; sampled every clk.
- change_in  in  1  request: return one change coin; sampled every clk.
- motor_done  in  1  item-drop sensor; 1 = item delivered.
- fault_clr  in  1  clears fault and ovf.
- motor_on  out  1  dispense motor drive.
- coin_ret  out  1  change solenoid drive.
- q_full  out  1  queue holds QDEPTH entries.
- busy  out  1  state != IDLE, or queue non-empty.
- fault  out  1  sticky dispense timeout.
- ovf  out  1  sticky: request dropped because the queue was full.
- vend_count  out  8  successful vends, saturating at 255.

Behaviour:
- Reset, asynchronous: state=IDLE, queue emptied, timer=0. All outputs 0, including vend_count. Reset takes effect immediately mid-pulse; motor_on and coin_ret drop without waiting for clk.
- Push:
  - Any cycle with vend_in|change_in=1 pushes entry {v=vend_in, c=change_in}.
  - If the queue is full at that edge, the entry is discarded and ovf is set. This applies even if a pop happens on the same edge.
  - A push and a pop on the same edge when not full: both occur, and occupancy is unchanged.
  - Occupancy ranges 0..QDEPTH. q_full is registered from occupancy.
- FSM: IDLE, DISPENSE, RETURN, FAULT. motor_on and coin_ret are registered and equal to the state decode.
- IDLE:
  - If the queue is non-empty, pop the head into cur.
  - cur.v=1: go to DISPENSE. Else cur.c=1: go to RETURN. Both cannot be 0.
- DISPENSE:
  - motor_on=1. The timer counts clocks in this state, starting at 1.
  - motor_done=1 sampled: motor_on drops on the next edge and vend_count increments, saturating at 255. Next state is RETURN if cur.c, else IDLE.
  - Timer reaches TIMEOUT_CYCLES without motor_done: go to FAULT with motor_on=0 and fault=1. vend_count is unchanged, and the cur change request is abandoned.
  - If motor_done and timeout coincide, motor_done wins.
- RETURN: coin_ret=1 for exactly PULSE_CYCLES clocks, then IDLE.
- FAULT:
  - motor_on=0, coin_ret=0. The queue still accepts pushes and does not pop.
  - fault_clr=1 returns the FSM to IDLE and clears fault and ovf on the same edge.
  - fault_clr outside FAULT clears ovf only.
- Latency: a request sampled on edge E0 with IDLE and an empty queue pops at E1. motor_on or coin_ret goes high after E1, i.e. 2 edges from request to drive.
- Back-to-back requests execute in FIFO order with one IDLE cycle between them.
- Simultaneous vend_in and change_in produce a single entry: dispense, then return change.
- Queue pointers are log2(QDEPTH) bits and wrap naturally.

Optional Feature:
- Macro: VEND_CTRL_RETRY_EN.
- Defined: the first timeout of a request does not fault. motor_on deasserts for exactly 1 clock, then DISPENSE re-enters with the timer reset. Only a second timeout of the same request enters FAULT. A retry_used flag is held per request and cleared on pop.
- Undefined: the first timeout enters FAULT, and no retry logic is present.

Test Plan:
- Use PULSE_CYCLES=4, TIMEOUT_CYCLES=16, QDEPTH=4 for all scenarios.
- Single vend: vend_in pulse at E0, motor_done at the 5th motor_on cycle -> motor_on high for 5 cycles starting after E1; vend_count=1; then IDLE and busy=0.
- Vend plus change: vend_in=change_in=1 for one cycle, motor_done after 3 cycles -> motor_on for 3 cycles, then coin_ret for exactly 4 cycles; vend_count=1.
- Overflow: 6 change_in pulses while FSM is in FAULT -> q_full=1 after 4 pushes and ovf=1. After fault_clr, exactly 4 coin_ret pulses of 4 cycles each, separated by 1 idle cycle.
- Timeout: vend with motor_done held 0 -> motor_on for exactly 16 cycles, then fault=1; vend_count unchanged. fault_clr -> IDLE.
- Reset mid-RETURN: assert reset during the 2nd coin_ret cycle -> coin_ret=0 immediately; q_full=0, busy=0 and vend_count=0 after release.
- RETRY_EN defined, motor_done held 0 -> motor_on 16 cycles, 1 low cycle, 16 cycles, then fault=1. With motor_done during the retry -> no fault and vend_count=1.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// vend_dispense_ctrl
// Sequences the dispense motor and the change-return solenoid. One-cycle vend
// and change requests from the coin FSM are queued, then executed one at a time
// with a drop-sensor handshake, a dispense timeout and sticky fault reporting.
//
// Optional build macro: VEND_CTRL_RETRY_EN
//   defined   : the first dispense timeout of a request drops the motor for one
//               clock and re-runs the dispense; only a second timeout faults.
//   undefined : the first timeout faults; no retry logic is built.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   vend_in     request: dispense one item
//   change_in   request: return one change coin
//   motor_done  item-drop sensor, 1 = item delivered
//   fault_clr   clears fault (in FAULT) and ovf
//   motor_on    dispense motor drive (registered)
//   coin_ret    change solenoid drive (registered)
//   q_full      queue holds QDEPTH entries
//   busy        FSM not idle, or queue non-empty
//   fault       sticky dispense timeout
//   ovf         sticky: a request was dropped on a full queue
//   vend_count  successful vends, saturating at 255
// -----------------------------------------------------------------------------
module vend_dispense_ctrl #(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int QDEPTH         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vend_in,
    input  logic       change_in,
    input  logic       motor_done,
    input  logic       fault_clr,
    output logic       motor_on,
    output logic       coin_ret,
    output logic       q_full,
    output logic       busy,
    output logic       fault,
    output logic       ovf,
    output logic [7:0] vend_count
);
    localparam int AW   = $clog2(QDEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (TIMEOUT_CYCLES > PULSE_CYCLES) ? TIMEOUT_CYCLES : PULSE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] DEPTH_C   = CW'(QDEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] PULSE_T   = TW'(PULSE_CYCLES);
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DISPENSE = 3'd1,
        S_RETURN   = 3'd2,
        S_FAULT    = 3'd3
`ifdef VEND_CTRL_RETRY_EN
        ,
        S_RETRY    = 3'd4
`endif
    } state_t;

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic          cur_c_r;
    logic          motor_on_r;
    logic          coin_ret_r;
    logic          busy_r;
    logic          fault_r;
    logic [7:0]    vend_count_r;
`ifdef VEND_CTRL_RETRY_EN
    logic          retry_used_r;
`endif

    // Queue entries are {v, c}
    logic [1:0]    q_mem_r [QDEPTH];
    logic [AW-1:0] q_wr_r;
    logic [AW-1:0] q_rd_r;
    logic [CW-1:0] q_cnt_r;
    logic          q_full_r;
    logic          ovf_r;

    logic          push_req_s;
    logic          q_full_now_s;
    logic          push_ok_s;
    logic          pop_s;
    logic [1:0]    head_s;
    logic [CW-1:0] q_cnt_n_s;
    logic          timeout_s;
    logic          pulse_end_s;
    logic          to_idle_s;

    // Queue control, timer decodes and whether the FSM will be idle after this edge
    always_comb begin
        push_req_s   = vend_in | change_in;
        // Fullness is judged on occupancy before this edge, so a same-edge pop
        // does not make room for the incoming request.
        q_full_now_s = (q_cnt_r == DEPTH_C);
        push_ok_s    = push_req_s & ~q_full_now_s;
        pop_s        = (state_r == S_IDLE) && (q_cnt_r != '0);
        head_s       = q_mem_r[q_rd_r];
        timeout_s    = (timer_r == TIMEOUT_T);
        pulse_end_s  = (timer_r == PULSE_T);

        if (push_ok_s && !pop_s) begin
            q_cnt_n_s = q_cnt_r + CNT_ONE;
        end else if (!push_ok_s && pop_s) begin
            q_cnt_n_s = q_cnt_r - CNT_ONE;
        end else begin
            q_cnt_n_s = q_cnt_r;
        end

        case (state_r)
            S_IDLE:     to_idle_s = ~pop_s;
            S_DISPENSE: to_idle_s = motor_done & ~cur_c_r;
            S_RETURN:   to_idle_s = pulse_end_s;
            S_FAULT:    to_idle_s = fault_clr;
`ifdef VEND_CTRL_RETRY_EN
            S_RETRY:    to_idle_s = 1'b0;
`endif
            default:    to_idle_s = 1'b1;
        endcase
    end

    // Queue storage write port (contents are only read while occupancy is non-zero)
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            q_mem_r[q_wr_r] <= {vend_in, change_in};
        end
    end

    // Queue pointers, occupancy, q_full and the sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_wr_r   <= '0;
            q_rd_r   <= '0;
            q_cnt_r  <= '0;
            q_full_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                q_wr_r <= q_wr_r + PTR_ONE;
            end
            if (pop_s) begin
                q_rd_r <= q_rd_r + PTR_ONE;
            end
            q_cnt_r  <= q_cnt_n_s;
            q_full_r <= (q_cnt_n_s == DEPTH_C);
            // A fresh drop outranks a clear on the same edge so it is never lost.
            if (push_req_s && q_full_now_s) begin
                ovf_r <= 1'b1;
            end else if (fault_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Actuator sequencing FSM with registered drives, fault, busy and vend counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            timer_r      <= '0;
            cur_c_r      <= 1'b0;
            motor_on_r   <= 1'b0;
            coin_ret_r   <= 1'b0;
            busy_r       <= 1'b0;
            fault_r      <= 1'b0;
            vend_count_r <= 8'd0;
`ifdef VEND_CTRL_RETRY_EN
            retry_used_r <= 1'b0;
`endif
        end else begin
            busy_r <= ~to_idle_s | (q_cnt_n_s != '0);
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        cur_c_r <= head_s[0];
                        timer_r <= T_ONE;
`ifdef VEND_CTRL_RETRY_EN
                        retry_used_r <= 1'b0;
`endif
                        // An entry always has v or c set; v runs first.
                        if (head_s[1]) begin
                            state_r    <= S_DISPENSE;
                            motor_on_r <= 1'b1;
                        end else begin
                            state_r    <= S_RETURN;
                            coin_ret_r <= 1'b1;
                        end
                    end
                end
                S_DISPENSE: begin
                    // motor_done is checked first so it wins over a same-cycle timeout.
                    if (motor_done) begin
                        motor_on_r <= 1'b0;
                        if (vend_count_r != 8'hFF) begin
                            vend_count_r <= vend_count_r + 8'd1;
                        end
                        if (cur_c_r) begin
                            state_r    <= S_RETURN;
                            coin_ret_r <= 1'b1;
                            timer_r    <= T_ONE;
                        end else begin
                            state_r <= S_IDLE;
                            timer_r <= '0;
                        end
                    end else if (timeout_s) begin
                        motor_on_r <= 1'b0;
                        timer_r    <= '0;
`ifdef VEND_CTRL_RETRY_EN
                        if (!retry_used_r) begin
                            state_r      <= S_RETRY;
                            retry_used_r <= 1'b1;
                        end else begin
                            state_r <= S_FAULT;
                            fault_r <= 1'b1;
                        end
`else
                        state_r <= S_FAULT;
                        fault_r <= 1'b1;
`endif
                    end else begin
                        timer_r <= timer_r + T_ONE;
                    end
                end
                S_RETURN: begin
                    if (pulse_end_s) begin
                        state_r    <= S_IDLE;
                        coin_ret_r <= 1'b0;
                        timer_r    <= '0;
                    end else begin
                        timer_r <= timer_r + T_ONE;
                    end
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        state_r <= S_IDLE;
                        fault_r <= 1'b0;
                    end
                end
`ifdef VEND_CTRL_RETRY_EN
                S_RETRY: begin
                    // One clock with the motor off, then a fresh dispense attempt.
                    state_r    <= S_DISPENSE;
                    motor_on_r <= 1'b1;
                    timer_r    <= T_ONE;
                end
`endif
                default: begin
                    state_r    <= S_IDLE;
                    motor_on_r <= 1'b0;
                    coin_ret_r <= 1'b0;
                    timer_r    <= '0;
                end
            endcase
        end
    end

    assign motor_on   = motor_on_r;
    assign coin_ret   = coin_ret_r;
    assign q_full     = q_full_r;
    assign busy       = busy_r;
    assign fault      = fault_r;
    assign ovf        = ovf_r;
    assign vend_count = vend_count_r;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for vend_dispense_ctrl (PULSE_CYCLES=4, TIMEOUT_CYCLES=16, QDEPTH=4).
// A request-level reference model (a queue of {v,c} entries plus the job being
// executed) predicts every output each cycle; directed scenarios pin the model
// with hand-computed literal expectations; randomized traffic follows.
// Honours VEND_CTRL_RETRY_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_vend_dispense_ctrl;
    localparam int PULSE = 4;
    localparam int TMO   = 16;
    localparam int DEPTH = 4;
`ifdef VEND_CTRL_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       vend_in;
    logic       change_in;
    logic       motor_done;
    logic       fault_clr;
    logic       motor_on;
    logic       coin_ret;
    logic       q_full;
    logic       busy;
    logic       fault;
    logic       ovf;
    logic [7:0] vend_count;

    int checks   = 0;
    int failures = 0;

    vend_dispense_ctrl #(
        .PULSE_CYCLES   (PULSE),
        .TIMEOUT_CYCLES (TMO),
        .QDEPTH         (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vend_in    (vend_in),
        .change_in  (change_in),
        .motor_done (motor_done),
        .fault_clr  (fault_clr),
        .motor_on   (motor_on),
        .coin_ret   (coin_ret),
        .q_full     (q_full),
        .busy       (busy),
        .fault      (fault),
        .ovf        (ovf),
        .vend_count (vend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE  = 0;
    localparam int M_MOTOR = 1;
    localparam int M_COIN  = 2;
    localparam int M_FAULT = 3;
    localparam int M_GAP   = 4;

    logic [1:0] mq[$];
    int m_mode;
    int m_elapsed;
    int m_coin_left;
    int m_vcount;
    bit m_change_after;
    bit m_retried;
    bit m_fault;
    bit m_ovf;

    task automatic m_reset();
        mq.delete();
        m_mode = M_IDLE; m_elapsed = 0; m_coin_left = 0; m_vcount = 0;
        m_change_after = 1'b0; m_retried = 1'b0; m_fault = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic m_step();
        int         old_size = mq.size();
        bit         req      = vend_in | change_in;
        logic [1:0] head;
        case (m_mode)
            M_IDLE: begin
                if (old_size > 0) begin
                    head      = mq.pop_front();
                    m_retried = 1'b0;
                    if (head[1]) begin
                        m_mode = M_MOTOR; m_elapsed = 1; m_change_after = head[0];
                    end else begin
                        m_mode = M_COIN; m_coin_left = PULSE;
                    end
                end
            end
            M_MOTOR: begin
                if (motor_done) begin
                    if (m_vcount < 255) m_vcount++;
                    if (m_change_after) begin
                        m_mode = M_COIN; m_coin_left = PULSE;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end else if (m_elapsed == TMO) begin
                    if (RETRY && !m_retried) begin
                        m_mode = M_GAP; m_retried = 1'b1;
                    end else begin
                        m_mode = M_FAULT; m_fault = 1'b1;
                    end
                end else begin
                    m_elapsed++;
                end
            end
            M_COIN: begin
                m_coin_left--;
                if (m_coin_left == 0) m_mode = M_IDLE;
            end
            M_GAP: begin
                m_mode = M_MOTOR; m_elapsed = 1;
            end
            M_FAULT: begin
                if (fault_clr) begin
                    m_mode = M_IDLE; m_fault = 1'b0;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        if (req && old_size == DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            if (req) mq.push_back({vend_in, change_in});
            if (fault_clr) m_ovf = 1'b0;
        end
    endtask

    initial begin : model_proc
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare_proc
        forever begin
            @(negedge clk);
            chk("motor_on",   motor_on,   m_mode == M_MOTOR);
            chk("coin_ret",   coin_ret,   m_mode == M_COIN);
            chk("q_full",     q_full,     mq.size() == DEPTH);
            chk("busy",       busy,       (m_mode != M_IDLE) || (mq.size() != 0));
            chk("fault",      fault,      m_fault);
            chk("ovf",        ovf,        m_ovf);
            chk("vend_count", vend_count, m_vcount);
        end
    end

    // ---------------- directed observation helper ----------------
    int obs_motor, obs_coin, obs_coin_rises;
    int obs_first_motor, obs_last_motor, obs_first_coin, obs_last_coin;

    // Runs n cycles, clearing one-cycle requests after the first edge; raises
    // motor_done during the md_at-th motor_on cycle (0 = never).
    task automatic observe(input int n, input int md_at);
        int mc        = 0;
        bit prev_coin = 1'b0;
        obs_motor = 0; obs_coin = 0; obs_coin_rises = 0;
        obs_first_motor = -1; obs_last_motor = -1;
        obs_first_coin  = -1; obs_last_coin  = -1;
        motor_done = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            vend_in = 1'b0; change_in = 1'b0; fault_clr = 1'b0;
            if (motor_on) begin
                obs_motor++; mc++; obs_last_motor = i;
                if (obs_first_motor < 0) obs_first_motor = i;
            end
            if (coin_ret) begin
                obs_coin++; obs_last_coin = i;
                if (!prev_coin) obs_coin_rises++;
                if (obs_first_coin < 0) obs_first_coin = i;
            end
            prev_coin  = coin_ret;
            motor_done = motor_on && (md_at > 0) && (mc == md_at);
        end
        motor_done = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim_proc
        reset = 1'b1; vend_in = 1'b0; change_in = 1'b0; motor_done = 1'b0; fault_clr = 1'b0;
        @(negedge clk);
        chk("reset_state", {motor_on, coin_ret, q_full, busy, fault, ovf, vend_count}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single vend, drop sensed in the 5th motor cycle
        vend_in = 1'b1;
        observe(20, 5);
        chk("s1_first_motor", obs_first_motor, 2);
        chk("s1_motor_cycles", obs_motor, 5);
        chk("s1_vend_count", vend_count, 1);
        chk("s1_busy", busy, 0);

        // Vend plus change in one entry
        vend_in = 1'b1; change_in = 1'b1;
        observe(20, 3);
        chk("s2_motor_cycles", obs_motor, 3);
        chk("s2_coin_cycles", obs_coin, 4);
        chk("s2_coin_pulses", obs_coin_rises, 1);
        chk("s2_first_coin", obs_first_coin, 5);
        chk("s2_vend_count", vend_count, 2);
        chk("s2_busy", busy, 0);

        // Timeout with no drop sensed
        vend_in = 1'b1;
        observe(45, 0);
        chk("s4_motor_cycles", obs_motor, RETRY ? 32 : 16);
        chk("s4_last_motor", obs_last_motor, RETRY ? 34 : 17);
        chk("s4_fault", fault, 1);
        chk("s4_vend_count", vend_count, 2);
        chk("s4_busy", busy, 1);

        // Overflow while faulted: 6 change pushes into a 4-deep queue
        for (int k = 0; k < 6; k++) begin
            change_in = 1'b1;
            @(negedge clk);
            chk("s3_q_full", q_full, k >= 3);
        end
        change_in = 1'b0;
        chk("s3_ovf", ovf, 1);
        chk("s3_fault_held", fault, 1);
        fault_clr = 1'b1;
        observe(45, 0);
        chk("s3_coin_pulses", obs_coin_rises, 4);
        chk("s3_coin_cycles", obs_coin, 16);
        chk("s3_first_coin", obs_first_coin, 2);
        chk("s3_last_coin", obs_last_coin, 20);
        chk("s3_ovf_cleared", ovf, 0);
        chk("s3_fault_cleared", fault, 0);
        chk("s3_busy", busy, 0);

        // Drop sensed in the 20th motor cycle: inside the retry when enabled
        vend_in = 1'b1;
        observe(45, 20);
        chk("s6_motor_cycles", obs_motor, RETRY ? 20 : 16);
        chk("s6_fault", fault, RETRY ? 0 : 1);
        chk("s6_vend_count", vend_count, RETRY ? 3 : 2);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);

        // Reset during the 2nd coin_ret cycle with vends queued behind it
        change_in = 1'b1;
        @(negedge clk);
        change_in = 1'b0; vend_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vend_in = 1'b0;
        chk("s5_coin_before", coin_ret, 1);
        #2 reset = 1'b1;
        #1;
        chk("s5_coin_async", coin_ret, 0);
        chk("s5_busy_async", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("s5_q_full", q_full, 0);
        chk("s5_busy", busy, 0);
        chk("s5_vend_count", vend_count, 0);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            vend_in    = ($urandom_range(0, 9) == 0);
            change_in  = ($urandom_range(0, 9) == 0);
            motor_done = ($urandom_range(0, 13) == 0);
            fault_clr  = ($urandom_range(0, 24) == 0);
        end

        // Continuous successful vends to drive vend_count into saturation
        @(negedge clk);
        vend_in = 1'b0; change_in = 1'b0; motor_done = 1'b1; fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0; vend_in = 1'b1;
        repeat (800) @(negedge clk);
        vend_in = 1'b0; motor_done = 1'b0;
        repeat (40) @(negedge clk);
        chk("sat_vend_count", vend_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
